// File: rtl/decode_regfile_sb_if.sv
// rtl/decode_regfile_sb_if.sv - bus bundle between decode logic and the register file/scoreboard
// Purpose: groups read ports, write/writeback port, load issue port and status outputs.
// Signals:
//   rd_addr/rd_use -> rd_data   NREAD read ports, port i at [i*AW +: AW] / [i*DATA_W +: DATA_W]
//   wr_en/wr_addr/wr_data/wr_ld  write port; wr_ld marks a load writeback
//   iss_en/iss_addr              load issue, marks destination busy
//   stall/busy_vec/stall_cnt     scoreboard status
// Modports: master drives requests, slave is the register file.
interface decode_regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int CNT_W  = 16
);
  localparam int AW = $clog2(NREGS);

  logic [NREAD*AW-1:0]     rd_addr;
  logic [NREAD-1:0]        rd_use;
  logic [NREAD*DATA_W-1:0] rd_data;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    wr_ld;
  logic                    iss_en;
  logic [AW-1:0]           iss_addr;
  logic                    stall;
  logic [NREGS-1:0]        busy_vec;
  logic [CNT_W-1:0]        stall_cnt;

  modport master (
    output rd_addr, rd_use, wr_en, wr_addr, wr_data, wr_ld, iss_en, iss_addr,
    input  rd_data, stall, busy_vec, stall_cnt
  );

  modport slave (
    input  rd_addr, rd_use, wr_en, wr_addr, wr_data, wr_ld, iss_en, iss_addr,
    output rd_data, stall, busy_vec, stall_cnt
  );
endinterface

// File: rtl/decode_regfile_sb.sv
// rtl/decode_regfile_sb.sv - decode-stage register file with load scoreboard and stall counter
// Purpose: NREAD combinational read ports, one synchronous write port, optional write->read
//   bypass, optional hardwired zero register, per-register busy bits for outstanding loads,
//   stall generation for reads of busy registers and a wrapping stall-cycle counter.
// Ports:
//   clk  clock, all state updates on posedge
//   rst  asynchronous active-high reset
//   bus  decode_regfile_sb_if.slave (read/write/issue ports and status outputs)
module decode_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  decode_regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0]       regs [NREGS];
  logic [NREGS-1:0]        busy;
  logic [NREGS-1:0]        busy_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [NREAD-1:0]        hit;
  logic [NREAD*DATA_W-1:0] rd;
  logic                    stall;
  logic                    wr_ok;
  logic                    ld_clr;

  // Writes to the hardwired zero register are dropped entirely.
  assign wr_ok  = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));
  assign ld_clr = bus.wr_en && bus.wr_ld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wr_ok) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Issue is applied after clear so a load issuing onto a register whose previous
  // load is writing back this cycle leaves it busy.
  always_comb begin
    busy_nxt = busy;
    if (ld_clr) busy_nxt[bus.wr_addr] = 1'b0;
    if (bus.iss_en) busy_nxt[bus.iss_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      busy <= busy_nxt;
      if (stall) cnt <= cnt + CNT_W'(1);
    end
  end

  // Read ports and per-port busy hits. A load writing back in the same cycle is
  // forwarded (when bypassing), so its pending busy bit must not stall the reader.
  always_comb begin
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] d;
    logic              fwd_clr;
    hit = '0;
    rd  = '0;
    for (int i = 0; i < NREAD; i++) begin
      a = bus.rd_addr[i*AW +: AW];
      d = regs[a];
      if ((BYPASS != 0) && wr_ok && (bus.wr_addr == a)) d = bus.wr_data;
      if ((ZERO_REG != 0) && (a == '0)) d = '0;
      rd[i*DATA_W +: DATA_W] = d;
      fwd_clr = (BYPASS != 0) && ld_clr && (bus.wr_addr == a);
      hit[i]  = bus.rd_use[i] && busy[a] && !fwd_clr;
    end
  end

  assign stall         = |hit;
  assign bus.stall     = stall;
  assign bus.rd_data   = rd;
  assign bus.busy_vec  = busy;
  assign bus.stall_cnt = cnt;
endmodule

// File: tb/tb_decode_regfile_sb.sv
// tb/tb_decode_regfile_sb.sv - self-checking bench for decode_regfile_sb (bypass and non-bypass builds)
module tb_decode_regfile_sb;
  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic [1:0]  rd_use = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_ld = 1'b0;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_regfile_sb_if #(.DATA_W(32), .NREGS(32), .NREAD(2), .CNT_W(4)) ifb ();
  decode_regfile_sb_if #(.DATA_W(32), .NREGS(32), .NREAD(2), .CNT_W(4)) ifn ();

  assign ifb.rd_addr = rd_addr;   assign ifn.rd_addr = rd_addr;
  assign ifb.rd_use = rd_use;     assign ifn.rd_use = rd_use;
  assign ifb.wr_en = wr_en;       assign ifn.wr_en = wr_en;
  assign ifb.wr_addr = wr_addr;   assign ifn.wr_addr = wr_addr;
  assign ifb.wr_data = wr_data;   assign ifn.wr_data = wr_data;
  assign ifb.wr_ld = wr_ld;       assign ifn.wr_ld = wr_ld;
  assign ifb.iss_en = iss_en;     assign ifn.iss_en = iss_en;
  assign ifb.iss_addr = iss_addr; assign ifn.iss_addr = iss_addr;

  decode_regfile_sb #(.DATA_W(32), .NREGS(32), .NREAD(2), .BYPASS(1), .ZERO_REG(1), .CNT_W(4))
    u_byp (.clk(clk), .rst(rst), .bus(ifb));
  decode_regfile_sb #(.DATA_W(32), .NREGS(32), .NREAD(2), .BYPASS(0), .ZERO_REG(1), .CNT_W(4))
    u_nobyp (.clk(clk), .rst(rst), .bus(ifn));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Behavioural model: architectural register contents, set of outstanding loads,
  // and one stall tally per bypass flavour.
  logic [31:0] mreg [32];
  logic [31:0] mbusy;
  int          mcnt_b;
  int          mcnt_n;

  function automatic logic [31:0] exp_rd(input int i, input bit byp);
    logic [4:0] a;
    a = rd_addr[i*AW +: AW];
    if (a == 0) return 32'h0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return mreg[a];
  endfunction

  function automatic bit exp_stall(input bit byp);
    logic [4:0] a;
    bit s;
    s = 0;
    for (int i = 0; i < 2; i++) begin
      a = rd_addr[i*AW +: AW];
      if (rd_use[i] && mbusy[a] && !(byp && wr_en && wr_ld && wr_addr == a)) s = 1;
    end
    return s;
  endfunction

  function automatic logic [31:0] next_busy();
    logic [31:0] nb;
    nb = mbusy;
    if (wr_en && wr_ld) nb[wr_addr] = 1'b0;
    if (iss_en) nb[iss_addr] = 1'b1;
    nb[0] = 1'b0;
    return nb;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) mreg[r] <= '0;
      mbusy  <= '0;
      mcnt_b <= 0;
      mcnt_n <= 0;
    end else begin
      if (wr_en && wr_addr != 0) mreg[wr_addr] <= wr_data;
      mbusy <= next_busy();
      if (exp_stall(1)) mcnt_b <= (mcnt_b + 1) % 16;
      if (exp_stall(0)) mcnt_n <= (mcnt_n + 1) % 16;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("byp_rd_data[%0d]", i), 64'(ifb.rd_data[i*32 +: 32]), 64'(exp_rd(i, 1)));
      chk($sformatf("nobyp_rd_data[%0d]", i), 64'(ifn.rd_data[i*32 +: 32]), 64'(exp_rd(i, 0)));
    end
    chk("byp_stall", 64'(ifb.stall), 64'(exp_stall(1)));
    chk("nobyp_stall", 64'(ifn.stall), 64'(exp_stall(0)));
    chk("byp_busy_vec", 64'(ifb.busy_vec), 64'(mbusy));
    chk("nobyp_busy_vec", 64'(ifn.busy_vec), 64'(mbusy));
    chk("byp_stall_cnt", 64'(ifb.stall_cnt), 64'(mcnt_b));
    chk("nobyp_stall_cnt", 64'(ifn.stall_cnt), 64'(mcnt_n));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_use = '0; wr_en = 1'b0; wr_ld = 1'b0; iss_en = 1'b0;
    wr_addr = '0; wr_data = '0; iss_addr = '0;
  endtask

  initial begin
    // Reset state, ports reading registers 0 and 5
    rd_addr = {5'd5, 5'd0};
    tick(); tick();
    #2;
    chk("L_reset_rd0", 64'(ifb.rd_data[31:0]), 64'h0);
    chk("L_reset_rd1", 64'(ifb.rd_data[63:32]), 64'h0);
    chk("L_reset_busy", 64'(ifb.busy_vec), 64'h0);
    chk("L_reset_stall", 64'(ifb.stall), 64'h0);
    chk("L_reset_cnt", 64'(ifb.stall_cnt), 64'h0);
    rst = 1'b0;

    // Write with same-cycle read of the same register
    tick();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd5};
    #3;
    chk("L_bypass_same", 64'(ifb.rd_data[31:0]), 64'hDEADBEEF);
    chk("L_nobypass_same", 64'(ifn.rd_data[31:0]), 64'h0);
    tick(); idle();
    #3;
    chk("L_byp_next", 64'(ifb.rd_data[31:0]), 64'hDEADBEEF);
    chk("L_nobyp_next", 64'(ifn.rd_data[31:0]), 64'hDEADBEEF);

    // Zero register: write and issue are ignored
    tick();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; iss_en = 1'b1; iss_addr = 5'd0;
    rd_addr = {5'd0, 5'd0}; rd_use = 2'b11;
    #3;
    chk("L_zero_same", 64'(ifb.rd_data[31:0]), 64'h0);
    tick(); idle(); rd_use = 2'b11;
    #3;
    chk("L_zero_rd", 64'(ifb.rd_data[63:32]), 64'h0);
    chk("L_zero_busy", 64'(ifb.busy_vec[0]), 64'h0);
    chk("L_zero_stall", 64'(ifb.stall), 64'h0);

    // Load-use: issue does not stall in its own cycle, then three stall cycles
    tick(); idle();
    iss_en = 1'b1; iss_addr = 5'd8; rd_addr = {5'd8, 5'd0}; rd_use = 2'b10;
    #3;
    chk("L_iss_same_stall", 64'(ifb.stall), 64'h0);
    tick(); iss_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("L_loaduse_stall", 64'(ifb.stall), 64'h1);
      tick();
    end
    wr_en = 1'b1; wr_ld = 1'b1; wr_addr = 5'd8; wr_data = 32'h55;
    #3;
    chk("L_wb_stall_byp", 64'(ifb.stall), 64'h0);
    chk("L_wb_stall_nobyp", 64'(ifn.stall), 64'h1);
    chk("L_wb_rd1", 64'(ifb.rd_data[63:32]), 64'h55);
    chk("L_wb_cnt", 64'(ifb.stall_cnt), 64'h3);
    tick(); idle(); rd_addr = {5'd8, 5'd0}; rd_use = 2'b10;
    #3;
    chk("L_after_cnt_byp", 64'(ifb.stall_cnt), 64'h3);
    chk("L_after_cnt_nobyp", 64'(ifn.stall_cnt), 64'h4);
    chk("L_after_stall", 64'(ifb.stall), 64'h0);

    // Set/clear collision on register 8
    tick(); idle(); rd_addr = {5'd8, 5'd0};
    iss_en = 1'b1; iss_addr = 5'd8;
    tick();
    wr_en = 1'b1; wr_ld = 1'b1; wr_addr = 5'd8; wr_data = 32'h77;
    tick(); idle(); rd_addr = {5'd8, 5'd0};
    #3;
    chk("L_collide_busy8", 64'(ifb.busy_vec[8]), 64'h1);
    chk("L_collide_reg8", 64'(ifb.rd_data[63:32]), 64'h77);

    // Reset mid-load discards busy state
    tick(); idle();
    iss_en = 1'b1; iss_addr = 5'd3;
    tick(); idle(); rd_addr = {5'd0, 5'd3}; rd_use = 2'b01;
    #1;
    chk("L_pre_rst_busy3", 64'(ifb.busy_vec[3]), 64'h1);
    rst = 1'b1;
    #1;
    chk("L_rst_busy", 64'(ifb.busy_vec), 64'h0);
    chk("L_rst_stall", 64'(ifb.stall), 64'h0);
    chk("L_rst_cnt", 64'(ifb.stall_cnt), 64'h0);
    rst = 1'b0;

    // Counter wrap: 17 stall cycles on a 4-bit counter leaves 1
    tick(); idle();
    iss_en = 1'b1; iss_addr = 5'd3;
    tick(); idle(); rd_addr = {5'd0, 5'd3}; rd_use = 2'b01;
    for (int k = 0; k < 17; k++) tick();
    idle();
    #3;
    chk("L_wrap_cnt", 64'(ifb.stall_cnt), 64'h1);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
